// File: rtl/ex_mul_sequencer.sv
// -----------------------------------------------------------------------------
// ex_mul_sequencer
//
// Execute-stage consumer of the 186-bit decode/execute bundle. The block
// unpacks the bundle. For MUL-class instructions it runs a 32-step shift-add
// unsigned multiply. While the multiply is in flight it holds decode and fetch
// through 'stall'. When the multiply completes it presents a one-cycle HI/LO
// result toward memory/writeback. Non-MUL bundles, including all-zero bubbles,
// are ignored because the single-cycle ALU path handles them.
//
// Ports
//   clk        in   1    system clock (bundle changes on negedge)
//   rst_n      in   1    asynchronous active-low reset
//   d_bundle   in   186  {rt, rd, rtData, imm, rsData, pc, pc1, controls}
//   flush      in   1    kill an in-flight multiply (branch redirect)
//   stall      out  1    hold decode register and fetch (combinational)
//   busy       out  1    FSM is iterating
//   res_valid  out  1    one-cycle result strobe
//   res_wen    out  1    res_valid && res_dest != 0
//   res_dest   out  5    destination register
//   res_hi     out  32   product[63:32]
//   res_lo     out  32   product[31:0]
//   res_pc     out  32   pc of the multiply's bundle
// -----------------------------------------------------------------------------
module ex_mul_sequencer #(
  parameter int CTRL_MUL_BIT = 5,
  parameter int CTRL_RD_BIT  = 6,
  parameter int ITER         = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [185:0] d_bundle,
  input  logic         flush,
  output logic         stall,
  output logic         busy,
  output logic         res_valid,
  output logic         res_wen,
  output logic [4:0]   res_dest,
  output logic [31:0]  res_hi,
  output logic [31:0]  res_lo,
  output logic [31:0]  res_pc
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bundle fields
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_rt_data;
  logic [31:0] w_rs_data;
  logic [31:0] w_pc;
  logic [15:0] w_ctrl;

  assign w_rt      = d_bundle[185:181];
  assign w_rd      = d_bundle[180:176];
  assign w_rt_data = d_bundle[175:144];
  assign w_rs_data = d_bundle[111:80];
  assign w_pc      = d_bundle[79:48];
  assign w_ctrl    = d_bundle[15:0];

  state_t           r_state;
  logic [64:0]      r_product;   // one extra bit keeps the carry of each add
  logic [31:0]      r_mcand;
  logic [31:0]      r_mplier;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_dest;
  logic [31:0]      r_pc;

  logic        w_start;
  logic [64:0] w_sum;
  logic [64:0] w_next;
  logic        w_last;

  // NOTE: every signal assigned in an always_comb gets a default on entry,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_sum   = r_product;
    w_start = 1'b0;
    stall   = 1'b0;
    // Gating with rst_n keeps stall low while reset is held, even when a MUL
    // bundle is sitting on the input.
    w_start = rst_n && (r_state == S_IDLE) && w_ctrl[CTRL_MUL_BIT] && !flush;
    stall   = w_start || ((r_state == S_BUSY) && !flush);
    if (r_mplier[0]) begin
      w_sum = r_product + {1'b0, r_mcand, 32'b0};
    end
  end

  assign w_next = w_sum >> 1;
  assign w_last = (r_count == CNT_W'(ITER - 1));

  // NOTE: all state in this block uses non-blocking assignments. Every
  // right-hand side then sees values from before the clock edge, whatever
  // the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_product <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_dest    <= '0;
      r_pc      <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_wen   <= 1'b0;
      res_dest  <= '0;
      res_hi    <= '0;
      res_lo    <= '0;
      res_pc    <= '0;
    end else begin
      // Strobes last one cycle. The result fields hold until the next DONE.
      res_valid <= 1'b0;
      res_wen   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_BUSY;
            busy      <= 1'b1;
            r_mcand   <= w_rs_data;
            r_mplier  <= w_rt_data;
            r_product <= '0;
            r_count   <= '0;
            r_dest    <= w_ctrl[CTRL_RD_BIT] ? w_rd : w_rt;
            r_pc      <= w_pc;
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_product <= w_next;
            r_mplier  <= r_mplier >> 1;
            r_count   <= r_count + 1'b1;
            if (w_last) begin
              // The final iteration's result goes straight to the outputs,
              // so the strobe is high for the whole DONE cycle.
              r_state   <= S_DONE;
              busy      <= 1'b0;
              res_valid <= 1'b1;
              res_wen   <= (r_dest != 5'd0);
              res_dest  <= r_dest;
              res_hi    <= w_next[63:32];
              res_lo    <= w_next[31:0];
              res_pc    <= r_pc;
            end
          end
        end
        S_DONE: begin
          // The bundle still shows the completed MUL until the next negedge,
          // so no new capture happens here.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_sequencer.sv
module tb_ex_mul_sequencer;

  localparam int MUL_BIT = 5;
  localparam int RD_BIT  = 6;

  logic         clk;
  logic         rst_n;
  logic [185:0] d_bundle;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         res_valid;
  logic         res_wen;
  logic [4:0]   res_dest;
  logic [31:0]  res_hi;
  logic [31:0]  res_lo;
  logic [31:0]  res_pc;

  ex_mul_sequencer #(
    .CTRL_MUL_BIT(MUL_BIT),
    .CTRL_RD_BIT (RD_BIT),
    .ITER        (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_bundle (d_bundle),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .res_valid(res_valid),
    .res_wen  (res_wen),
    .res_dest (res_dest),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .res_pc   (res_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        wen;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding multiply.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 64'(res_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_hi",   64'(res_hi),   64'(e.hi));
        check("res_lo",   64'(res_lo),   64'(e.lo));
        check("res_dest", 64'(res_dest), 64'(e.dest));
        check("res_wen",  64'(res_wen),  64'(e.wen));
        check("res_pc",   64'(res_pc),   64'(e.pc));
      end
    end
  end

  function automatic logic [185:0] mk_bundle(input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [31:0] rt_data, input logic [31:0] rs_data,
                                             input logic [31:0] pc, input logic [15:0] ctrl);
    logic [31:0] imm;
    logic [31:0] pc1;
    imm = $urandom;
    pc1 = $urandom;
    return {rt, rd, rt_data, imm, rs_data, pc, pc1, ctrl};
  endfunction

  // Random bundle that is not a MUL (the ALU path owns it).
  task automatic set_non_mul();
    logic [15:0] c;
    c = 16'($urandom);
    c[MUL_BIT] = 1'b0;
    d_bundle = mk_bundle(5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, c);
  endtask

  // Drives a MUL bundle. If 'expect_result' is set, the result predicted by
  // the reference model is queued.
  task automatic set_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [4:0] rt, input logic rdbit, input logic expect_result);
    logic [15:0] c;
    logic [31:0] pc;
    logic [63:0] prod;
    exp_t e;
    c = 16'($urandom);
    c[MUL_BIT] = 1'b1;
    c[RD_BIT]  = rdbit;
    pc = $urandom;
    d_bundle = mk_bundle(rt, rd, b, a, pc, c);
    if (expect_result) begin
      prod   = 64'(a) * 64'(b);
      e.hi   = prod[63:32];
      e.lo   = prod[31:0];
      e.pc   = pc;
      e.dest = rdbit ? rd : rt;
      e.wen  = (e.dest != 5'd0);
      exp_q.push_back(e);
      last_exp = e;
    end
  endtask

  // Waits (bounded) for stall to rise and checks how many cycles that took.
  task automatic wait_start(input int exp_gap);
    int gap;
    #1;
    gap = 0;
    while (!stall && gap < 4) begin
      @(negedge clk); #1;
      gap++;
    end
    check("start_gap", 64'(gap), 64'(exp_gap));
  endtask

  // Counts stall cycles, from the start cycle through the last BUSY cycle.
  // The task returns in the DONE cycle.
  task automatic count_stall();
    int cnt;
    cnt = 0;
    while (stall && cnt < 100) begin
      cnt++;
      @(negedge clk); #1;
    end
    check("stall_cycles", 64'(cnt), 64'd33);
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [4:0] rt, input logic rdbit, input int exp_gap);
    set_mul(a, b, rd, rt, rdbit, 1'b1);
    wait_start(exp_gap);
    count_stall();
  endtask

  task automatic idle_cycles(input int n, input logic use_non_mul);
    for (int i = 0; i < n; i++) begin
      if (use_non_mul) set_non_mul();
      else d_bundle = '0;
      #1;
      check("idle_stall", 64'(stall), 64'd0);
      check("idle_busy",  64'(busy),  64'd0);
      @(negedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {stall, busy, res_valid, res_wen, res_dest, 32'd0}, 64'd0);
    check({tag, "_hi_lo"}, {res_hi, res_lo}, 64'd0);
    check({tag, "_pc"}, 64'(res_pc), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_gap;
    // 1: reset with a random MUL-looking bundle on the input
    rst_n = 1'b0;
    flush = 1'b0;
    set_mul($urandom, $urandom, 5'($urandom), 5'($urandom), 1'b1, 1'b0);
    #1;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    d_bundle = '0;
    rst_n    = 1'b1;
    #1;
    idle_cycles(3, 1'b0);
    check("post_reset_valid", 64'(res_valid), 64'd0);

    // 2: 7*6 into rd=9
    run_mul(32'd7, 32'd6, 5'd9, 5'($urandom), 1'b1, 0);
    idle_cycles(1, 1'b0);

    // 3: max*max into rt=0 (no write enable)
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'($urandom), 5'd0, 1'b0, 0);
    idle_cycles(1, 1'b0);

    // 4: flush at count 10. The earlier result must stay on the outputs.
    set_mul(32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 5'd4, 1'b1, 1'b0);
    wait_start(0);
    repeat (11) @(negedge clk);
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_stall_comb", 64'(stall), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("flush_idle_busy",  64'(busy),  64'd0);
      check("flush_idle_stall", 64'(stall), 64'd0);
    end
    flush = 1'b0;
    idle_cycles(40, 1'b0);
    check("flush_hold_hi_lo", {res_hi, res_lo}, {last_exp.hi, last_exp.lo});
    check("flush_hold_dest_pc", {27'd0, res_dest, res_pc}, {27'd0, last_exp.dest, last_exp.pc});

    // 5: back-to-back MULs. The second one starts one cycle after DONE.
    run_mul(32'd3, 32'd5, 5'($urandom), 5'($urandom), 1'($urandom), 0);
    run_mul(32'h0001_0000, 32'h0001_0000, 5'($urandom), 5'($urandom), 1'($urandom), 1);
    idle_cycles(5, 1'b1);

    // Random multiplies, some back-to-back and some separated by non-MUL bundles
    next_gap = 0;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'd0;
      if (i == 1) b = 32'd1;
      if (i == 2) b = 32'h8000_0000;
      run_mul(a, b, 5'($urandom), 5'($urandom), 1'($urandom), next_gap);
      if ($urandom_range(0, 1) == 1) begin
        idle_cycles($urandom_range(1, 3), 1'($urandom));
        next_gap = 0;
      end else begin
        next_gap = 1;
      end
    end
    idle_cycles(1, 1'b0);

    // 6: rst_n pulsed low at count 20
    set_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd7, 5'd8, 1'b1, 1'b0);
    wait_start(0);
    repeat (21) @(negedge clk);
    #1;
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    d_bundle = '0;
    rst_n    = 1'b1;
    #1;
    idle_cycles(40, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
